// File: rtl/wb_stage_pkg.sv
// wb_stage shared definitions: load-type codes and FSM states.
// Optional trace port set is enabled with WB_TRACE_EN.
package wb_stage_pkg;

   localparam int PC_WIDTH = 32;
   localparam int BYTE_W   = 8;
   localparam int HALF_W   = 16;

   typedef enum logic [2:0] {
      LT_LB  = 3'b000,
      LT_LH  = 3'b001,
      LT_LW  = 3'b010,
      LT_LBU = 3'b100,
      LT_LHU = 3'b101
   } load_type_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      WRITE     = 2'd2
   } state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage -> write-back handshake bundle.
// master = memory stage side, slave = wb_stage.
interface wb_stage_if
   import wb_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [PC_WIDTH-1:0]   in_pc;
   logic [ADDR_WIDTH-1:0] in_rd;
   logic                  in_rd_wen;
   logic                  in_is_load;
   logic [2:0]            in_load_type;
   logic [1:0]            in_addr_lo;
   logic [DATA_WIDTH-1:0] in_result;
   logic                  mem_rdata_valid;
   logic                  mem_rdata_ready;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output in_valid, in_pc, in_rd, in_rd_wen,
      output in_is_load, in_load_type, in_addr_lo,
      output in_result, mem_rdata_valid, mem_rdata,
      input  in_ready, mem_rdata_ready
   );

   modport slave (
      input  in_valid, in_pc, in_rd, in_rd_wen,
      input  in_is_load, in_load_type, in_addr_lo,
      input  in_result, mem_rdata_valid, mem_rdata,
      output in_ready, mem_rdata_ready
   );
endinterface

// File: rtl/wb_stage_load_align.sv
// Lane select and sign/zero extension of a raw memory word.
// Unknown load codes fall back to a full-word load.
module wb_stage_load_align
   import wb_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [2:0]            load_type,
   input  logic [1:0]            addr_lo,
   output logic [DATA_WIDTH-1:0] data
);

   logic [BYTE_W-1:0] byte_lane;
   logic [HALF_W-1:0] half_lane;

   // pick the addressed lane, then extend per load kind
   always_comb begin
      byte_lane = rdata[0 +: BYTE_W];
      case (addr_lo)
         2'd1:    byte_lane = rdata[BYTE_W +: BYTE_W];
         2'd2:    byte_lane = rdata[2*BYTE_W +: BYTE_W];
         2'd3:    byte_lane = rdata[3*BYTE_W +: BYTE_W];
         default: byte_lane = rdata[0 +: BYTE_W];
      endcase
      half_lane = addr_lo[1] ? rdata[HALF_W +: HALF_W]
                             : rdata[0 +: HALF_W];
      case (load_type)
         LT_LB:
            data = {{(DATA_WIDTH-BYTE_W){byte_lane[BYTE_W-1]}},
                    byte_lane};
         LT_LBU:
            data = {{(DATA_WIDTH-BYTE_W){1'b0}}, byte_lane};
         LT_LH:
            data = {{(DATA_WIDTH-HALF_W){half_lane[HALF_W-1]}},
                    half_lane};
         LT_LHU:
            data = {{(DATA_WIDTH-HALF_W){1'b0}}, half_lane};
         default:
            data = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one register-file write per retiring instruction.
// Define WB_TRACE_EN to add the trace_* retirement outputs.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   wb_stage_if.slave             up,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] busy_rd
`ifdef WB_TRACE_EN
   ,
   output logic                  trace_valid,
   output logic [PC_WIDTH-1:0]   trace_pc,
   output logic [ADDR_WIDTH-1:0] trace_rd,
   output logic [DATA_WIDTH-1:0] trace_data
`endif
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;
   logic                  rd_wen_q, rd_wen_d;
   logic [2:0]            load_type_q, load_type_d;
   logic [1:0]            addr_lo_q, addr_lo_d;
   logic                  rf_wen_q, rf_wen_d;
   logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

   logic                  accept;
   logic                  wr_go;
   logic [ADDR_WIDTH-1:0] wr_rd;
   logic                  wr_wen;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] load_word;

`ifdef WB_TRACE_EN
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [PC_WIDTH-1:0]   wr_pc;
   logic                  trace_valid_q, trace_valid_d;
   logic [PC_WIDTH-1:0]   trace_pc_q, trace_pc_d;
   logic [ADDR_WIDTH-1:0] trace_rd_q, trace_rd_d;
   logic [DATA_WIDTH-1:0] trace_data_q, trace_data_d;
`endif

   wb_stage_load_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .rdata     (up.mem_rdata),
      .load_type (load_type_q),
      .addr_lo   (addr_lo_q),
      .data      (load_word)
   );

   // IDLE and WRITE both take a new instruction
   assign up.in_ready        = !rst && (state_q != WAIT_DATA);
   assign up.mem_rdata_ready = !rst && (state_q == WAIT_DATA);
   assign accept             = up.in_valid && up.in_ready;

   // next state; wr_go marks the cycle before a WRITE cycle
   always_comb begin
      state_d     = state_q;
      rd_d        = rd_q;
      rd_wen_d    = rd_wen_q;
      load_type_d = load_type_q;
      addr_lo_d   = addr_lo_q;
      wr_go       = 1'b0;
      wr_rd       = rd_q;
      wr_wen      = rd_wen_q;
      wr_data     = load_word;
`ifdef WB_TRACE_EN
      pc_d        = pc_q;
      wr_pc       = pc_q;
`endif
      case (state_q)
         WAIT_DATA: begin
            if (up.mem_rdata_valid) begin
               wr_go = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            if (accept) begin
               rd_d        = up.in_rd;
               rd_wen_d    = up.in_rd_wen;
               load_type_d = up.in_load_type;
               addr_lo_d   = up.in_addr_lo;
`ifdef WB_TRACE_EN
               pc_d        = up.in_pc;
`endif
               if (up.in_is_load) begin
                  state_d = WAIT_DATA;
               end else begin
                  wr_go   = 1'b1;
                  wr_rd   = up.in_rd;
                  wr_wen  = up.in_rd_wen;
                  wr_data = up.in_result;
`ifdef WB_TRACE_EN
                  wr_pc   = up.in_pc;
`endif
               end
            end
         end
      endcase
      if (wr_go) begin
         state_d = WRITE;
      end
   end

   // write port values; address/data hold outside WRITE
   always_comb begin
      rf_wen_d   = wr_go && wr_wen && (wr_rd != '0);
      rf_waddr_d = wr_go ? wr_rd : rf_waddr_q;
      rf_wdata_d = wr_go ? wr_data : rf_wdata_q;
`ifdef WB_TRACE_EN
      trace_valid_d = wr_go;
      trace_pc_d    = wr_go ? wr_pc : trace_pc_q;
      trace_rd_d    = wr_go ? wr_rd : trace_rd_q;
      trace_data_d  = wr_go ? wr_data : trace_data_q;
`endif
   end

   // pending-write view for decode hazard checks
   always_comb begin
      busy    = 1'b0;
      busy_rd = '0;
      if (!rst && state_q == WAIT_DATA) begin
         busy = 1'b1;
         if (rd_wen_q) begin
            busy_rd = rd_q;
         end
      end else if (state_q == WRITE && accept) begin
         busy = 1'b1;
         if (up.in_rd_wen) begin
            busy_rd = up.in_rd;
         end
      end
   end

   // state and field registers; reset drops any in-flight work
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_q        <= '0;
         rd_wen_q    <= 1'b0;
         load_type_q <= '0;
         addr_lo_q   <= '0;
         rf_wen_q    <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         rd_wen_q    <= rd_wen_d;
         load_type_q <= load_type_d;
         addr_lo_q   <= addr_lo_d;
         rf_wen_q    <= rf_wen_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wdata_q  <= rf_wdata_d;
      end
   end

   // a write pending when reset arrives is suppressed
   assign rf_wen   = rf_wen_q && !rst;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

`ifdef WB_TRACE_EN
   // retirement trace registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= '0;
         trace_valid_q <= 1'b0;
         trace_pc_q    <= '0;
         trace_rd_q    <= '0;
         trace_data_q  <= '0;
      end else begin
         pc_q          <= pc_d;
         trace_valid_q <= trace_valid_d;
         trace_pc_q    <= trace_pc_d;
         trace_rd_q    <= trace_rd_d;
         trace_data_q  <= trace_data_d;
      end
   end

   assign trace_valid = trace_valid_q;
   assign trace_pc    = trace_pc_q;
   assign trace_rd    = trace_rd_q;
   assign trace_data  = trace_data_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed, table and random.
// Trace outputs are checked when WB_TRACE_EN is defined.
module tb_wb_stage;
   import wb_stage_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          busy;
   logic [AW-1:0] busy_rd;
`ifdef WB_TRACE_EN
   logic          trace_valid;
   logic [31:0]   trace_pc;
   logic [AW-1:0] trace_rd;
   logic [DW-1:0] trace_data;
`endif

   always #5 clk = ~clk;

   wb_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   wb_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .up          (bus),
      .rf_wen      (rf_wen),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .busy        (busy),
      .busy_rd     (busy_rd)
`ifdef WB_TRACE_EN
      ,
      .trace_valid (trace_valid),
      .trace_pc    (trace_pc),
      .trace_rd    (trace_rd),
      .trace_data  (trace_data)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0]  lt;
      logic [1:0]  lo;
      logic [31:0] rdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[13];

   // reference model state for the random phase
   bit          m_ld;
   logic [4:0]  m_ld_rd;
   bit          m_ld_wen;
   logic [2:0]  m_ld_lt;
   logic [1:0]  m_ld_lo;
   logic [31:0] m_ld_pc;
   bit          m_wr;
   logic [4:0]  m_wr_rd;
   bit          m_wr_en;
   logic [31:0] m_wr_data;
   logic [31:0] m_wr_pc;
   logic [4:0]  m_last_addr;
   logic [31:0] m_last_data;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive_in(input logic v, input logic [31:0] pc,
                           input logic [4:0] rd, input logic wen,
                           input logic ld, input logic [2:0] lt,
                           input logic [1:0] lo,
                           input logic [31:0] res);
      bus.in_valid     = v;
      bus.in_pc        = pc;
      bus.in_rd        = rd;
      bus.in_rd_wen    = wen;
      bus.in_is_load   = ld;
      bus.in_load_type = lt;
      bus.in_addr_lo   = lo;
      bus.in_result    = res;
   endtask

   task automatic idle_in();
      drive_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0);
   endtask

   // spec-level extraction: shift, mask, and two's-complement wrap
   function automatic logic [31:0] ref_extract(
      input logic [2:0] lt, input logic [1:0] lo,
      input logic [31:0] w);
      int          width;
      bit          sgn;
      int          sh;
      longint      v;
      longint      half;
      case (lt)
         3'b000:  begin width = 8;  sgn = 1'b1; end
         3'b100:  begin width = 8;  sgn = 1'b0; end
         3'b001:  begin width = 16; sgn = 1'b1; end
         3'b101:  begin width = 16; sgn = 1'b0; end
         default: begin width = 32; sgn = 1'b0; end
      endcase
      if (width == 32) return w;
      sh   = (width == 8) ? 8 * int'(lo) : 16 * (int'(lo) / 2);
      v    = (longint'(w) >> sh) & ((longint'(1) << width) - 1);
      half = longint'(1) << (width - 1);
      if (sgn && v >= half) v = v - 2 * half + 64'h1_0000_0000;
      return v[31:0];
   endfunction

   task automatic run_load(input logic [2:0] lt, input logic [1:0] lo,
                           input logic [31:0] rdata,
                           input logic [4:0] rd, input int gap,
                           input logic [31:0] exp,
                           input string name);
      edge_();
      drive_in(1'b1, 32'h100, rd, 1'b1, 1'b1, lt, lo, 32'h5A5A5A5A);
      mid();
      edge_();
      idle_in();
      for (int k = 0; k < gap; k++) begin
         mid();
         chk({name, "_in_ready"}, bus.in_ready, 32'd0);
         chk({name, "_mrr"}, bus.mem_rdata_ready, 32'd1);
         chk({name, "_busy_rd"}, busy_rd, rd);
         edge_();
      end
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = rdata;
      mid();
      chk({name, "_mrr_hs"}, bus.mem_rdata_ready, 32'd1);
      chk({name, "_wen_early"}, rf_wen, 32'd0);
      edge_();
      bus.mem_rdata_valid = 1'b0;
      mid();
      chk({name, "_wen"}, rf_wen, 32'd1);
      chk({name, "_waddr"}, rf_waddr, rd);
      chk({name, "_wdata"}, rf_wdata, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: no finish at time %0t", $time);
      $fatal(1);
   end

   initial begin
      logic        e_ready;
      logic        e_wen;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic        acc;
      logic        e_busy;
      logic [4:0]  e_brd;

      vecs[0]  = '{3'b000, 2'd3, 32'h80FF0011, 32'hFFFFFF80};
      vecs[1]  = '{3'b100, 2'd3, 32'h80FF0011, 32'h00000080};
      vecs[2]  = '{3'b000, 2'd0, 32'h80FF0011, 32'h00000011};
      vecs[3]  = '{3'b000, 2'd2, 32'h80FF0011, 32'hFFFFFFFF};
      vecs[4]  = '{3'b100, 2'd2, 32'h80FF0011, 32'h000000FF};
      vecs[5]  = '{3'b101, 2'd2, 32'h8001ABCD, 32'h00008001};
      vecs[6]  = '{3'b001, 2'd2, 32'h8001ABCD, 32'hFFFF8001};
      vecs[7]  = '{3'b001, 2'd1, 32'h8001ABCD, 32'hFFFFABCD};
      vecs[8]  = '{3'b101, 2'd3, 32'h8001ABCD, 32'h00008001};
      vecs[9]  = '{3'b010, 2'd1, 32'h8001ABCD, 32'h8001ABCD};
      vecs[10] = '{3'b111, 2'd2, 32'h80FF0011, 32'h80FF0011};
      vecs[11] = '{3'b011, 2'd0, 32'h12345678, 32'h12345678};
      vecs[12] = '{3'b110, 2'd3, 32'hFF00FF80, 32'hFF00FF80};

      rst = 1'b1;
      idle_in();
      bus.mem_rdata_valid = 1'b0;
      bus.mem_rdata       = '0;

      // reset state
      repeat (2) @(posedge clk);
      mid();
      chk("rst_in_ready", bus.in_ready, 32'd0);
      edge_();
      rst = 1'b0;
      mid();
      chk("rst_wen", rf_wen, 32'd0);
      chk("rst_waddr", rf_waddr, 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_busy_rd", busy_rd, 32'd0);
      chk("rst_mrr", bus.mem_rdata_ready, 32'd0);
      chk("rst_in_ready_lo", bus.in_ready, 32'd1);
`ifdef WB_TRACE_EN
      chk("rst_trace_valid", trace_valid, 32'd0);
      chk("rst_trace_pc", trace_pc, 32'd0);
`endif

      // non-load: write exactly one cycle after accept
      edge_();
      drive_in(1'b1, 32'h40, 5'd5, 1'b1, 1'b0, 3'd0, 2'd0,
               32'h12345678);
      mid();
      chk("nl_in_ready", bus.in_ready, 32'd1);
      chk("nl_wen_pre", rf_wen, 32'd0);
      edge_();
      idle_in();
      mid();
      chk("nl_wen", rf_wen, 32'd1);
      chk("nl_waddr", rf_waddr, 32'd5);
      chk("nl_wdata", rf_wdata, 32'h12345678);
      chk("nl_busy", busy, 32'd0);
      edge_();
      mid();
      chk("nl_wen_post", rf_wen, 32'd0);
      chk("nl_wdata_hold", rf_wdata, 32'h12345678);

      // LB with data four cycles after accept
      run_load(3'b000, 2'd3, 32'h80FF0011, 5'd9, 3, 32'hFFFFFF80,
               "lb_wait");

      // table of load extractions
      for (int i = 0; i < 13; i++) begin
         run_load(vecs[i].lt, vecs[i].lo, vecs[i].rdata,
                  5'(i + 1), i % 3, vecs[i].exp,
                  $sformatf("vec%0d", i));
      end

      // rd=0: passes WRITE without a write
      edge_();
      drive_in(1'b1, 32'h80, 5'd0, 1'b1, 1'b0, 3'd0, 2'd0,
               32'h0000DEAD);
      mid();
      edge_();
      idle_in();
      mid();
      chk("rd0_wen", rf_wen, 32'd0);
      chk("rd0_wdata", rf_wdata, 32'h0000DEAD);
      chk("rd0_busy", busy, 32'd0);
      edge_();
      mid();
      chk("rd0_wen_post", rf_wen, 32'd0);
      chk("rd0_in_ready", bus.in_ready, 32'd1);
      chk("rd0_mrr", bus.mem_rdata_ready, 32'd0);

      // three back-to-back non-loads
      edge_();
      drive_in(1'b1, 32'h200, 5'd1, 1'b1, 1'b0, 3'd0, 2'd0, 32'hA1);
      mid();
      edge_();
      drive_in(1'b1, 32'h204, 5'd2, 1'b1, 1'b0, 3'd0, 2'd0, 32'hB2);
      mid();
      chk("b2b0_wen", rf_wen, 32'd1);
      chk("b2b0_waddr", rf_waddr, 32'd1);
      chk("b2b0_wdata", rf_wdata, 32'hA1);
      chk("b2b0_busy_rd", busy_rd, 32'd2);
      edge_();
      drive_in(1'b1, 32'h208, 5'd3, 1'b1, 1'b0, 3'd0, 2'd0, 32'hC3);
      mid();
      chk("b2b1_wen", rf_wen, 32'd1);
      chk("b2b1_waddr", rf_waddr, 32'd2);
      chk("b2b1_wdata", rf_wdata, 32'hB2);
      edge_();
      idle_in();
      mid();
      chk("b2b2_wen", rf_wen, 32'd1);
      chk("b2b2_waddr", rf_waddr, 32'd3);
      chk("b2b2_wdata", rf_wdata, 32'hC3);
      edge_();
      mid();
      chk("b2b_end_wen", rf_wen, 32'd0);

      // reset raised while waiting for load data
      edge_();
      drive_in(1'b1, 32'h300, 5'd12, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
      mid();
      edge_();
      idle_in();
      mid();
      chk("rmid_mrr_wait", bus.mem_rdata_ready, 32'd1);
      edge_();
      rst                 = 1'b1;
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = 32'h77777777;
      mid();
      chk("rmid_wen_in_rst", rf_wen, 32'd0);
      chk("rmid_in_ready_rst", bus.in_ready, 32'd0);
      edge_();
      rst = 1'b0;
      mid();
      chk("rmid_wen", rf_wen, 32'd0);
      chk("rmid_waddr", rf_waddr, 32'd0);
      chk("rmid_wdata", rf_wdata, 32'd0);
      chk("rmid_busy", busy, 32'd0);
      chk("rmid_busy_rd", busy_rd, 32'd0);
      chk("rmid_mrr", bus.mem_rdata_ready, 32'd0);
      chk("rmid_in_ready", bus.in_ready, 32'd1);
      edge_();
      bus.mem_rdata_valid = 1'b0;
      drive_in(1'b1, 32'h400, 5'd3, 1'b1, 1'b0, 3'd0, 2'd0,
               32'h0000CAFE);
      mid();
      chk("rmid_wen_stray", rf_wen, 32'd0);
      edge_();
      idle_in();
      mid();
      chk("fresh_wen", rf_wen, 32'd1);
      chk("fresh_waddr", rf_waddr, 32'd3);
      chk("fresh_wdata", rf_wdata, 32'h0000CAFE);

      // random traffic against the reference model
      m_ld        = 1'b0;
      m_wr        = 1'b0;
      m_last_addr = 5'd3;
      m_last_data = 32'h0000CAFE;
      for (int c = 0; c < 3000; c++) begin
         edge_();
         bus.in_valid        = ($urandom_range(0, 3) != 0);
         bus.in_pc           = $urandom;
         bus.in_rd           = 5'($urandom_range(0, 7));
         bus.in_rd_wen       = ($urandom_range(0, 3) != 0);
         bus.in_is_load      = ($urandom_range(0, 2) == 0);
         bus.in_load_type    = 3'($urandom_range(0, 7));
         bus.in_addr_lo      = 2'($urandom_range(0, 3));
         bus.in_result       = $urandom;
         bus.mem_rdata_valid = ($urandom_range(0, 2) == 0);
         bus.mem_rdata       = $urandom;
         mid();
         e_ready = !m_ld;
         e_wen   = m_wr && m_wr_en;
         e_addr  = m_wr ? m_wr_rd : m_last_addr;
         e_data  = m_wr ? m_wr_data : m_last_data;
         acc     = bus.in_valid && e_ready;
         e_busy  = m_ld || (m_wr && acc);
         e_brd   = 5'd0;
         if (m_ld && m_ld_wen) e_brd = m_ld_rd;
         else if (!m_ld && m_wr && acc && bus.in_rd_wen)
            e_brd = bus.in_rd;
         chk("rnd_in_ready", bus.in_ready, e_ready);
         chk("rnd_mrr", bus.mem_rdata_ready, m_ld);
         chk("rnd_wen", rf_wen, e_wen);
         chk("rnd_waddr", rf_waddr, e_addr);
         chk("rnd_wdata", rf_wdata, e_data);
         chk("rnd_busy", busy, e_busy);
         chk("rnd_busy_rd", busy_rd, e_brd);
`ifdef WB_TRACE_EN
         chk("rnd_trace_valid", trace_valid, m_wr);
         if (m_wr) begin
            chk("rnd_trace_pc", trace_pc, m_wr_pc);
            chk("rnd_trace_rd", trace_rd, m_wr_rd);
            chk("rnd_trace_data", trace_data, m_wr_data);
         end
`endif
         m_last_addr = e_addr;
         m_last_data = e_data;
         m_wr        = 1'b0;
         if (m_ld && bus.mem_rdata_valid) begin
            m_ld      = 1'b0;
            m_wr      = 1'b1;
            m_wr_rd   = m_ld_rd;
            m_wr_en   = m_ld_wen && (m_ld_rd != 5'd0);
            m_wr_data = ref_extract(m_ld_lt, m_ld_lo, bus.mem_rdata);
            m_wr_pc   = m_ld_pc;
         end else if (acc) begin
            if (bus.in_is_load) begin
               m_ld     = 1'b1;
               m_ld_rd  = bus.in_rd;
               m_ld_wen = bus.in_rd_wen;
               m_ld_lt  = bus.in_load_type;
               m_ld_lo  = bus.in_addr_lo;
               m_ld_pc  = bus.in_pc;
            end else begin
               m_wr      = 1'b1;
               m_wr_rd   = bus.in_rd;
               m_wr_en   = bus.in_rd_wen && (bus.in_rd != 5'd0);
               m_wr_data = bus.in_result;
               m_wr_pc   = bus.in_pc;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
